// File: rtl/mem_channel_responder_if.sv
// Multi-channel valid/ready memory bus between an initiator (master) and the responder (slave).
interface mem_channel_responder_if #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4
);
  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/mem_channel_responder.sv
// Multi-channel memory responder: one word array, one fixed-latency FSM per channel,
// plus a host preload port.
module mem_channel_responder #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 2,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_channel_responder_if.slave bus,
  input  logic                 load_valid,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data
);

  localparam int unsigned Depth  = 2 ** ADDR_BITS;
  localparam logic [3:0]  RdLoad = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WrLoad = 4'(WRITE_LATENCY - 1);
  localparam bit          WrEn   = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {StIdle, StReadWait, StWriteWait, StRespond, StDone} state_e;

  state_e                  state_q [NUM_CHANNELS];
  state_e                  state_d [NUM_CHANNELS];
  logic [3:0]              cnt_q   [NUM_CHANNELS];
  logic [3:0]              cnt_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    wdata_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    rdata_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] is_read_q, is_read_d;
  logic [NUM_CHANNELS-1:0] rd_commit, wr_commit;
  logic [DATA_BITS-1:0]    mem_q   [Depth];

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      addr_d[i]    = addr_q[i];
      wdata_d[i]   = wdata_q[i];
      is_read_d[i] = is_read_q[i];
      rd_commit[i] = 1'b0;
      wr_commit[i] = 1'b0;
      case (state_q[i])
        StIdle: begin
          // Read wins; a concurrent write stays pending until a later idle visit.
          if (bus.mem_read_valid[i]) begin
            state_d[i]   = StReadWait;
            cnt_d[i]     = RdLoad;
            addr_d[i]    = bus.mem_read_address[i];
            is_read_d[i] = 1'b1;
          end else if (WrEn && bus.mem_write_valid[i]) begin
            state_d[i]   = StWriteWait;
            cnt_d[i]     = WrLoad;
            addr_d[i]    = bus.mem_write_address[i];
            wdata_d[i]   = bus.mem_write_data[i];
            is_read_d[i] = 1'b0;
          end
        end
        StReadWait: begin
          if (cnt_q[i] == 4'd0) begin
            rd_commit[i] = 1'b1;
            state_d[i]   = StRespond;
          end else begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end
        end
        StWriteWait: begin
          if (cnt_q[i] == 4'd0) begin
            wr_commit[i] = 1'b1;
            state_d[i]   = StRespond;
          end else begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end
        end
        StRespond: state_d[i] = StDone;
        StDone: begin
          // Hold off until the initiator drops the valid that started this transaction.
          if (is_read_q[i] ? !bus.mem_read_valid[i] : !bus.mem_write_valid[i]) begin
            state_d[i] = StIdle;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
      is_read_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        addr_q[i]  <= addr_d[i];
        wdata_q[i] <= wdata_d[i];
        if (rd_commit[i]) rdata_q[i] <= mem_q[addr_q[i]];
      end
      is_read_q <= is_read_d;
    end
  end

  // Later assignments win: load first, then channels in ascending index order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < Depth; w++) mem_q[w] <= '0;
    end else begin
      if (load_valid) mem_q[load_address] <= load_data;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_commit[i]) mem_q[addr_q[i]] <= wdata_q[i];
      end
    end
  end

  always_comb begin
    bus.mem_read_ready  = '0;
    bus.mem_write_ready = '0;
    bus.mem_read_data   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      bus.mem_read_ready[i]  = (state_q[i] == StRespond) && is_read_q[i];
      bus.mem_write_ready[i] = WrEn && (state_q[i] == StRespond) && !is_read_q[i];
      bus.mem_read_data[i]   = rdata_q[i];
    end
  end

endmodule
